// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan
//   Display back-end for an 8-bit counter. A sampled binary value is
//   converted to 3-digit BCD by a sequential double-dabble engine, which
//   takes one cycle per bit. The committed BCD drives a time-multiplexed
//   3-digit 7-segment display, with optional leading-zero blanking.
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   ena       in   1   clock enable; low freezes every register
//   val_in    in   8   binary value to display (0..255)
//   val_load  in   1   single-cycle strobe that samples val_in
//   seg_out   out  7   segments {g,f,e,d,c,b,a}; inverted when COMMON_ANODE=1
//   dig_sel   out  3   one-hot digit enable (bit0 units .. bit2 hundreds)
//   bcd_out   out  12  committed BCD {hundreds, tens, units}
//   busy      out  1   conversion in progress
//
// Conversion FSM
//   state    | meaning
//   ST_IDLE  | waiting for val_load or a pending value
//   ST_SHIFT | one add-3/shift step per cycle, 8 steps in total
//   ST_DONE  | commit the BCD field to bcd_out
module bcd_7seg_scan #(
  parameter int SCAN_DIV      = 1000,
  parameter bit COMMON_ANODE  = 1'b0,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  val_in,
  input  logic        val_load,
  output logic [6:0]  seg_out,
  output logic [2:0]  dig_sel,
  output logic [11:0] bcd_out,
  output logic        busy
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_RST = 7'h3F ^ {7{COMMON_ANODE}};
  localparam logic [2:0] DIG_RST = 3'b001 ^ {3{COMMON_ANODE}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [19:0]    shreg;
  logic [2:0]     step;
  logic           pending;
  logic [7:0]     pend_val;
  logic [PW-1:0]  presc;
  logic [1:0]     idx;
  logic           start;
  logic           commit;
  logic [7:0]     load_val;
  logic [3:0]     digit;
  logic           blank;
  logic [6:0]     seg_nxt;
  logic [2:0]     dig_nxt;

  // One double-dabble step: correct each BCD nibble, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (r[8+4*i +: 4] >= 4'd5)
        r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd3;
    end
    return {r[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else if (ena)
      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (val_load || pending) state_nxt = ST_SHIFT;
      ST_SHIFT: if (step == 3'd7) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state != ST_IDLE);
    start    = (state == ST_IDLE) && (val_load || pending);
    commit   = (state == ST_DONE);
    load_val = val_load ? val_in : pend_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      step     <= '0;
      bcd_out  <= '0;
      pending  <= 1'b0;
      pend_val <= '0;
    end else if (ena) begin
      if (start) begin
        shreg <= {12'h000, load_val};
        step  <= '0;
      end else if (state == ST_SHIFT) begin
        shreg <= dd_step(shreg);
        step  <= step + 3'd1;
      end

      if (commit)
        bcd_out <= shreg[19:8];

      // A load that arrives mid-conversion waits in a 1-deep slot; the
      // newest value wins. A direct load in IDLE supersedes the slot.
      if (val_load && busy) begin
        pending  <= 1'b1;
        pend_val <= val_in;
      end else if (start) begin
        pending  <= 1'b0;
      end
    end
  end

  // Scan prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (ena) begin
      if (presc == PRESC_TC) begin
        presc <= '0;
        idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Blanked digits still get their scan slot so brightness stays even.
  always_comb begin
    digit = bcd_out[3:0];
    blank = 1'b0;
    case (idx)
      2'd1: begin
        digit = bcd_out[7:4];
        blank = BLANK_LEADING && (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0);
      end
      2'd2: begin
        digit = bcd_out[11:8];
        blank = BLANK_LEADING && (bcd_out[11:8] == 4'd0);
      end
      default: ;
    endcase
    seg_nxt = blank ? 7'h00 : seg_decode(digit);
    dig_nxt = 3'b001 << idx;
  end

  // Segments and digit select share one register stage so they never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= SEG_RST;
      dig_sel <= DIG_RST;
    end else if (ena) begin
      seg_out <= seg_nxt ^ {7{COMMON_ANODE}};
      dig_sel <= dig_nxt ^ {3{COMMON_ANODE}};
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Testbench for bcd_7seg_scan. Two instances share all inputs: dut_a uses
// leading-zero blanking with an active-high display, dut_b shows all digits
// on an active-low display. Both scan with SCAN_DIV=4.
module tb_bcd_7seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  val_in = 8'd0;
  logic        val_load = 1'b0;
  logic [6:0]  seg_out, seg_b;
  logic [2:0]  dig_sel, dig_b;
  logic [11:0] bcd_out, bcd_b;
  logic        busy, busy_b;

  int total = 0;
  int bad = 0;
  int model_val = 0;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_7seg_scan #(.SCAN_DIV(4), .COMMON_ANODE(1'b0), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .val_in(val_in), .val_load(val_load),
    .seg_out(seg_out), .dig_sel(dig_sel), .bcd_out(bcd_out), .busy(busy)
  );

  bcd_7seg_scan #(.SCAN_DIV(4), .COMMON_ANODE(1'b1), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .val_in(val_in), .val_load(val_load),
    .seg_out(seg_b), .dig_sel(dig_b), .bcd_out(bcd_b), .busy(busy_b)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // d: 0 units, 1 tens, 2 hundreds
  function automatic logic [6:0] ref_seg(input int v, input int d, input bit bl);
    int h, t, n;
    h = v / 100;
    t = (v / 10) % 10;
    if (bl && d == 2 && h == 0) return 7'h00;
    if (bl && d == 1 && h == 0 && t == 0) return 7'h00;
    n = (d == 2) ? h : (d == 1) ? t : v % 10;
    return seg_tbl[n];
  endfunction

  function automatic int dig_idx(input logic [2:0] d);
    case (d)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic run_conv(input int v);
    logic [11:0] prev;
    bit ok;
    prev = bcd_out;
    ok = 1'b1;
    val_in = 8'(v);
    val_load = 1'b1;
    tick();
    val_load = 1'b0;
    val_in = 8'($urandom);
    for (int i = 0; i < 9; i++) begin
      if (busy !== 1'b1 || busy_b !== 1'b1 || bcd_out !== prev) ok = 1'b0;
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL busy_window val=%0d: busy/bcd changed early, want busy=1 bcd=%h for 9 cycles", v, prev);
    end
    total++;
    if (bcd_out !== ref_bcd(v) || bcd_b !== ref_bcd(v)) begin
      bad++;
      $display("FAIL bcd val=%0d: got %h/%h want %h", v, bcd_out, bcd_b, ref_bcd(v));
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_clear val=%0d: got %b want 0", v, busy);
    end
    model_val = v;
  endtask

  task automatic check_display();
    logic [2:0] seen_a, seen_b;
    logic [6:0] ws;
    int d;
    seen_a = '0;
    seen_b = '0;
    tick();
    for (int i = 0; i < 14; i++) begin
      tick();
      d = dig_idx(dig_sel);
      ws = (d >= 0) ? ref_seg(model_val, d, 1'b1) : 7'h7F;
      total++;
      if (d < 0 || seg_out !== ws) begin
        bad++;
        $display("FAIL disp_a val=%0d: dig=%b seg=%h want one-hot dig, seg=%h", model_val, dig_sel, seg_out, ws);
      end else seen_a[d] = 1'b1;
      d = dig_idx(~dig_b);
      ws = (d >= 0) ? ref_seg(model_val, d, 1'b0) : 7'h7F;
      total++;
      if (d < 0 || ~seg_b !== ws) begin
        bad++;
        $display("FAIL disp_b val=%0d: dig=%b seg=%h want inverted one-hot dig, inverted seg=%h", model_val, dig_b, seg_b, ws);
      end else seen_b[d] = 1'b1;
    end
    total++;
    if (seen_a !== 3'b111 || seen_b !== 3'b111) begin
      bad++;
      $display("FAIL disp_rotation: seen %b/%b want 111/111", seen_a, seen_b);
    end
  endtask

  task automatic check_reset_values(input string nm);
    total++;
    if (seg_out !== 7'h3F || dig_sel !== 3'b001 || busy !== 1'b0 || bcd_out !== 12'h000) begin
      bad++;
      $display("FAIL %s_a: seg=%h dig=%b busy=%b bcd=%h want 3f 001 0 000", nm, seg_out, dig_sel, busy, bcd_out);
    end
    total++;
    if (seg_b !== 7'h40 || dig_b !== 3'b110 || busy_b !== 1'b0 || bcd_b !== 12'h000) begin
      bad++;
      $display("FAIL %s_b: seg=%h dig=%b busy=%b bcd=%h want 40 110 0 000", nm, seg_b, dig_b, busy_b, bcd_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_reset_values("reset_init");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_conv(88);
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    model_val = 0;
    tick();
  endtask

  task automatic test_convert_255();
    run_conv(255);
    check_display();
  endtask

  task automatic test_blanking();
    run_conv(7);
    check_display();
    run_conv(100);
    check_display();
    for (int i = 0; i < 6; i++) begin
      run_conv(int'($urandom_range(0, 255)));
      check_display();
    end
  endtask

  task automatic test_pending(input int second, input bit third);
    logic [11:0] prev;
    int want2, e;
    prev = bcd_out;
    want2 = third ? 9 : second;
    val_in = 8'd42;
    val_load = 1'b1;
    tick();
    val_load = 1'b0;
    tick();
    tick();
    val_in = 8'(second);
    val_load = 1'b1;
    tick();
    val_load = 1'b0;
    e = 3;
    if (third) begin
      tick();
      val_in = 8'd9;
      val_load = 1'b1;
      tick();
      val_load = 1'b0;
      e = 5;
    end
    while (e < 8) begin
      tick();
      e++;
    end
    total++;
    if (bcd_out !== prev) begin
      bad++;
      $display("FAIL pend_early: got %h want %h", bcd_out, prev);
    end
    tick();
    total++;
    if (bcd_out !== 12'h042 || busy !== 1'b0) begin
      bad++;
      $display("FAIL pend_first: bcd=%h busy=%b want 042 0", bcd_out, busy);
    end
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL pend_restart: busy=%b want 1", busy);
    end
    repeat (8) tick();
    total++;
    if (bcd_out !== 12'h042) begin
      bad++;
      $display("FAIL pend_hold: bcd=%h want 042", bcd_out);
    end
    tick();
    total++;
    if (bcd_out !== ref_bcd(want2) || busy !== 1'b0) begin
      bad++;
      $display("FAIL pend_second: bcd=%h busy=%b want %h 0", bcd_out, busy, ref_bcd(want2));
    end
    model_val = want2;
  endtask

  task automatic test_ena_scan();
    logic [2:0] prev, expd;
    logic [11:0] prevb;
    int cnt, n;
    bit found, ok;
    prev = dig_sel;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (dig_sel !== prev) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL scan_start: dig_sel stuck at %b, want a change within 12 cycles", dig_sel);
    end
    prev = dig_sel;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      ena = !(k >= 6 && k < 11);
      tick();
      if (ena) cnt++;
      expd = (cnt == 4) ? {prev[1:0], prev[2]} : prev;
      if (cnt == 4) cnt = 0;
      total++;
      if (dig_sel !== expd) begin
        bad++;
        $display("FAIL scan_step k=%0d: got %b want %b", k, dig_sel, expd);
      end
      prev = expd;
    end
    ena = 1'b1;

    prevb = bcd_out;
    val_in = 8'd137;
    val_load = 1'b1;
    tick();
    val_load = 1'b0;
    n = 0;
    ok = 1'b1;
    for (int k = 0; k < 60 && n < 9; k++) begin
      ena = (k < 3) ? 1'b0 : ($urandom_range(0, 2) != 0);
      tick();
      if (ena) n++;
      if (n < 9 && (busy !== 1'b1 || bcd_out !== prevb)) ok = 1'b0;
    end
    ena = 1'b1;
    total++;
    if (!ok || n < 9) begin
      bad++;
      $display("FAIL ena_conv_window: enabled=%0d want 9 with busy=1 bcd=%h held", n, prevb);
    end
    total++;
    if (bcd_out !== ref_bcd(137) || busy !== 1'b0) begin
      bad++;
      $display("FAIL ena_conv_result: bcd=%h busy=%b want %h 0", bcd_out, busy, ref_bcd(137));
    end
    model_val = 137;
    check_display();
  endtask

  task automatic test_reset_midconv();
    bit ok;
    val_in = 8'd255;
    val_load = 1'b1;
    tick();
    val_in = 8'd9;
    tick();
    val_load = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    model_val = 0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy !== 1'b0 || bcd_out !== 12'h000) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL pend_discard: busy=%b bcd=%h want 0 000 after reset", busy, bcd_out);
    end
    run_conv(128);
    check_display();
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) run_conv(v);
  endtask

  initial begin
    test_reset();
    test_convert_255();
    test_blanking();
    run_conv(11);
    test_pending(200, 1'b0);
    check_display();
    run_conv(11);
    test_pending(200, 1'b1);
    check_display();
    test_ena_scan();
    test_reset_midconv();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
